// File: rtl/ysyx_22051013_data_axi_master_pkg.sv
// Shared AXI constants, FSM state encoding and mask helpers for the data-side AXI master.
// Used by ysyx_22051013_data_axi_master and ysyx_22051013_axi_size_enc.
package ysyx_22051013_data_axi_master_pkg;

    localparam logic [2:0] AXI_SIZE_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_8 = 3'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ysyx_22051013_AXIM_IDLE  = 3'd0,
        ysyx_22051013_AXIM_RADDR = 3'd1,
        ysyx_22051013_AXIM_RDATA = 3'd2,
        ysyx_22051013_AXIM_WADDR = 3'd3,
        ysyx_22051013_AXIM_WRESP = 3'd4,
        ysyx_22051013_AXIM_RESP  = 3'd5
    } axim_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] mask);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ysyx_22051013_axi_size_enc.sv
// Combinational byte-mask to AXI size encoder; flags masks whose popcount is not 1, 2, 4 or 8.
// Illegal masks still encode as an 8-byte beat so the strobe can pass through unchanged.
module ysyx_22051013_axi_size_enc
    import ysyx_22051013_data_axi_master_pkg::*;
(
    input  logic [7:0] i_mask,
    output logic [2:0] o_size,
    output logic       o_illegal
);

    always_comb begin
        o_size    = AXI_SIZE_8;
        o_illegal = 1'b0;
        case (popcount8(i_mask))
            4'd1:    o_size = AXI_SIZE_1;
            4'd2:    o_size = AXI_SIZE_2;
            4'd4:    o_size = AXI_SIZE_4;
            4'd8:    o_size = AXI_SIZE_8;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_22051013_data_axi_master.sv
// Single-outstanding, single-beat AXI4 master for dcache line traffic and uncached device accesses.
// Optional YSYX_22051013_AXI_RESP_CHECK_EN: report bad responses, id mismatches and illegal masks on resp_err.
module ysyx_22051013_data_axi_master
    import ysyx_22051013_data_axi_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_re,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_mask,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [ID_W-1:0]   awid,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    input  logic [ID_W-1:0]   bid,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [ID_W-1:0]   arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [ID_W-1:0]   rid
);

    localparam logic [ID_W-1:0] ID_VAL = ID_W'(AXI_ID);

    axim_state_e       r_state;
    axim_state_e       w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [7:0]        r_mask;
    logic [2:0]        r_size;
    logic              r_illegal;
    logic              r_aw_pend;
    logic              r_w_pend;
    logic [63:0]       r_rdata;
    logic              r_err;

    logic [2:0]        w_size;
    logic              w_illegal;
    logic              w_start;
    logic              w_r_fire;
    logic              w_b_fire;
    logic              w_aw_done;
    logic              w_w_done;
    logic              w_rd_err;
    logic              w_wr_err;
    logic              w_unused;

    ysyx_22051013_axi_size_enc u_size_enc (
        .i_mask    (req_mask),
        .o_size    (w_size),
        .o_illegal (w_illegal)
    );

    assign w_start   = (r_state == ysyx_22051013_AXIM_IDLE) && (req_we || req_re);
    assign w_r_fire  = (r_state == ysyx_22051013_AXIM_RDATA) && rvalid && rlast;
    assign w_b_fire  = (r_state == ysyx_22051013_AXIM_WRESP) && bvalid;
    // A channel whose handshake already happened counts as done in later cycles.
    assign w_aw_done = !r_aw_pend || awready;
    assign w_w_done  = !r_w_pend || wready;

`ifdef YSYX_22051013_AXI_RESP_CHECK_EN
    assign w_rd_err = r_illegal || (rresp != AXI_RESP_OKAY) || (rid != ID_VAL);
    assign w_wr_err = r_illegal || (bresp != AXI_RESP_OKAY) || (bid != ID_VAL);
    assign w_unused = ^req_addr;
`else
    assign w_rd_err = 1'b0;
    assign w_wr_err = 1'b0;
    assign w_unused = ^{req_addr, rresp, bresp, rid, bid, r_illegal};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ysyx_22051013_AXIM_IDLE: begin
                if (req_we)      w_next = ysyx_22051013_AXIM_WADDR;
                else if (req_re) w_next = ysyx_22051013_AXIM_RADDR;
            end
            ysyx_22051013_AXIM_RADDR: if (arready) w_next = ysyx_22051013_AXIM_RDATA;
            ysyx_22051013_AXIM_RDATA: if (rvalid && rlast) w_next = ysyx_22051013_AXIM_RESP;
            ysyx_22051013_AXIM_WADDR: if (w_aw_done && w_w_done) w_next = ysyx_22051013_AXIM_WRESP;
            ysyx_22051013_AXIM_WRESP: if (bvalid) w_next = ysyx_22051013_AXIM_RESP;
            ysyx_22051013_AXIM_RESP:  w_next = ysyx_22051013_AXIM_IDLE;
            default:                  w_next = ysyx_22051013_AXIM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ysyx_22051013_AXIM_IDLE;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_rdata   <= 64'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ysyx_22051013_AXIM_IDLE) && req_we) begin
                r_aw_pend <= 1'b1;
                r_w_pend  <= 1'b1;
            end else begin
                if (awvalid && awready) r_aw_pend <= 1'b0;
                if (wvalid && wready)   r_w_pend  <= 1'b0;
            end
            if (w_r_fire) begin
                r_rdata <= rdata;
                r_err   <= w_rd_err;
            end else if (w_b_fire) begin
                r_err   <= w_wr_err;
            end
        end
    end

    // Request fields are frozen when the transaction starts.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_addr    <= req_addr[ADDR_W-1:0];
            r_wdata   <= req_wdata;
            r_mask    <= req_mask;
            r_size    <= w_size;
            r_illegal <= w_illegal;
        end
    end

    assign arvalid    = (r_state == ysyx_22051013_AXIM_RADDR);
    assign araddr     = r_addr;
    assign arid       = ID_VAL;
    assign arlen      = 8'd0;
    assign arsize     = r_size;
    assign arburst    = AXI_BURST_INCR;
    assign rready     = (r_state == ysyx_22051013_AXIM_RDATA);

    assign awvalid    = (r_state == ysyx_22051013_AXIM_WADDR) && r_aw_pend;
    assign awaddr     = r_addr;
    assign awid       = ID_VAL;
    assign awlen      = 8'd0;
    assign awsize     = r_size;
    assign awburst    = AXI_BURST_INCR;
    assign wvalid     = (r_state == ysyx_22051013_AXIM_WADDR) && r_w_pend;
    assign wdata      = r_wdata;
    assign wstrb      = r_mask;
    assign wlast      = 1'b1;
    assign bready     = (r_state == ysyx_22051013_AXIM_WRESP);

    assign resp_valid = (r_state == ysyx_22051013_AXIM_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err && resp_valid;

endmodule

// File: tb/tb_ysyx_22051013_data_axi_master.sv
// Scoreboard bench for ysyx_22051013_data_axi_master with a negedge-driven AXI slave model.
// Honours YSYX_22051013_AXI_RESP_CHECK_EN for the expected resp_err values.
module tb_ysyx_22051013_data_axi_master;

`ifdef YSYX_22051013_AXI_RESP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_re, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_mask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'b00;
    logic [3:0]  bid = 4'd1;
    logic        arvalid;
    logic        arready = 1'b1;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] rdata = 64'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;
    logic [3:0]  rid = 4'd1;

    always #5 clk = ~clk;

    ysyx_22051013_data_axi_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_re(req_re), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic        chk_data;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic [63:0] d, input logic cd, input logic e, input int lat);
        exp_t x;
        x.rdata = d; x.chk_data = cd; x.err = e; x.t0 = cyc; x.lat = lat;
        sb.push_back(x);
    endtask

    // Monitor: pops one expectation per resp_valid pulse.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid required=none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                if (e.lat > 0) chk("resp_latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    // Slave model: outputs change on negedge; fires seen here complete on the following posedge.
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] rd_data_q[$];
    logic [1:0]  bresp_cfg = 2'b00;
    int aw_delay = 0, aw_wait = 0, rcnt = 0, bcnt = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic p_ar = 0, p_aw = 0, p_w = 0, p_r = 0, p_b = 0, aw_got = 0, w_got = 0;
    logic saw_aw_only = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rvalid = 0; rlast = 0; bvalid = 0; awready = 0;
            rcnt = 0; bcnt = 0; aw_wait = 0; aw_got = 0; w_got = 0;
            p_ar = 0; p_aw = 0; p_w = 0; p_r = 0; p_b = 0;
        end else begin
            if (p_ar) rcnt = 2;
            if (p_r) begin rvalid = 0; rlast = 0; end
            if (p_b) bvalid = 0;
            if (p_aw) begin awready = 0; aw_wait = 0; aw_got = 1; end
            if (p_w) w_got = 1;
            if (aw_got && w_got) begin bcnt = 2; aw_got = 0; w_got = 0; end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    rvalid = 1; rlast = 1; rresp = 2'b00; rid = 4'd1;
                    rdata = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 64'd0;
                end
            end
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin bvalid = 1; bresp = bresp_cfg; bid = 4'd1; end
            end
            if (awvalid && !awready) begin
                if (aw_wait >= aw_delay) awready = 1;
                else aw_wait++;
            end
            p_ar = arvalid && arready;
            p_aw = awvalid && awready;
            p_w  = wvalid && wready;
            p_r  = rvalid && rready;
            p_b  = bvalid && bready;
            if (awvalid && !wvalid) saw_aw_only = 1;
            if (p_ar) begin
                ar_cnt++;
                chk("araddr", {32'd0, araddr}, {32'd0, exp_addr});
                chk("arsize", {61'd0, arsize}, {61'd0, exp_size});
                chk("arlen", {56'd0, arlen}, 64'd0);
                chk("arburst_id", {58'd0, arburst, arid}, {58'd0, 2'b01, 4'd1});
            end
            if (p_aw) begin
                aw_cnt++;
                chk("awaddr", {32'd0, awaddr}, {32'd0, exp_addr});
                chk("awsize", {61'd0, awsize}, {61'd0, exp_size});
                chk("awlen_burst_id", {50'd0, awlen, awburst, awid}, {50'd0, 8'd0, 2'b01, 4'd1});
            end
            if (p_w) begin
                w_cnt++;
                chk("wstrb", {56'd0, wstrb}, {56'd0, exp_strb});
                chk("wdata", wdata, exp_wdata);
                chk("wlast", {63'd0, wlast}, 64'd1);
            end
        end
    end

    task automatic wait_resp(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 40);
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_resp required=resp_valid", name);
        end
    endtask

    task automatic set_req(input logic re, input logic we, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] m);
        req_addr = a; req_wdata = d; req_mask = m; req_re = re; req_we = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0, w0, r0, n;
        rst_n = 0; req_re = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_mask = 0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_rready", {63'd0, rready}, 64'd0);
        chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
        chk("rst_bready", {63'd0, bready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        rst_n = 1;
        @(negedge clk);

        // 1: plain 8-byte read
        exp_addr = 32'h8000_0010; exp_size = 3'd3;
        rd_data_q.push_back(64'h0123_4567_89AB_CDEF);
        push_exp(64'h0123_4567_89AB_CDEF, 1, 0, 4);
        set_req(1, 0, 64'h8000_0010, 64'd0, 8'hff);
        wait_resp("t1");
        req_re = 0;
        @(negedge clk);

        // 2: 4-byte write, awready late, wready immediate
        exp_addr = 32'h8000_0100; exp_size = 3'd2; exp_strb = 8'h0f; exp_wdata = 64'h1122_3344_5566_7788;
        aw_delay = 3; saw_aw_only = 0; w0 = w_cnt;
        push_exp(64'h0123_4567_89AB_CDEF, 1, 0, 7);
        set_req(0, 1, 64'h8000_0100, 64'h1122_3344_5566_7788, 8'h0f);
        wait_resp("t2");
        req_we = 0;
        chk("t2_wbeats", 64'(w_cnt - w0), 64'd1);
        chk("t2_w_before_aw", {63'd0, saw_aw_only}, 64'd1);
        aw_delay = 0;
        @(negedge clk);

        // 3: read and write together, write wins
        exp_addr = 32'h8000_0208; exp_size = 3'd3; exp_strb = 8'hff; exp_wdata = 64'hA5A5_0000_FFFF_5A5A;
        ar0 = ar_cnt; w0 = w_cnt; r0 = resp_cnt;
        push_exp(64'd0, 0, 0, 4);
        set_req(1, 1, 64'h8000_0208, 64'hA5A5_0000_FFFF_5A5A, 8'hff);
        wait_resp("t3");
        req_re = 0; req_we = 0;
        @(negedge clk);
        chk("t3_no_ar", 64'(ar_cnt - ar0), 64'd0);
        chk("t3_wbeats", 64'(w_cnt - w0), 64'd1);
        chk("t3_one_resp", 64'(resp_cnt - r0), 64'd1);

        // 4: reset while waiting for read data
        exp_addr = 32'h8000_0300; exp_size = 3'd3;
        set_req(1, 0, 64'h8000_0300, 64'd0, 8'hff);
        n = 0;
        do begin @(negedge clk); n++; end while (!rready && n < 20);
        chk("t4_in_rdata", {63'd0, rready}, 64'd1);
        rst_n = 0; req_re = 0;
        @(negedge clk);
        chk("t4_rready", {63'd0, rready}, 64'd0);
        chk("t4_arvalid", {63'd0, arvalid}, 64'd0);
        chk("t4_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("t4_rdata_cleared", resp_rdata, 64'd0);
        rst_n = 1; r0 = resp_cnt;
        repeat (6) @(negedge clk);
        chk("t4_no_resp", 64'(resp_cnt - r0), 64'd0);

        // 5: back-to-back reads with the request held through the first RESP
        exp_addr = 32'h8000_0400; exp_size = 3'd3; ar0 = ar_cnt;
        rd_data_q.push_back(64'hAAAA_1111_2222_3333);
        rd_data_q.push_back(64'h5555_6666_7777_8888);
        push_exp(64'hAAAA_1111_2222_3333, 1, 0, 4);
        push_exp(64'h5555_6666_7777_8888, 1, 0, 9);
        set_req(1, 0, 64'h8000_0400, 64'd0, 8'hff);
        wait_resp("t5a");
        wait_resp("t5b");
        req_re = 0;
        @(negedge clk);
        chk("t5_two_ar", 64'(ar_cnt - ar0), 64'd2);

        // 2-byte and 1-byte reads
        exp_addr = 32'h8000_0502; exp_size = 3'd1;
        rd_data_q.push_back(64'h0000_0000_BEEF_0000);
        push_exp(64'h0000_0000_BEEF_0000, 1, 0, 4);
        set_req(1, 0, 64'h8000_0502, 64'd0, 8'h0c);
        wait_resp("t5c");
        req_re = 0;
        @(negedge clk);
        exp_addr = 32'h8000_0504; exp_size = 3'd0;
        rd_data_q.push_back(64'h0000_0042_0000_0000);
        push_exp(64'h0000_0042_0000_0000, 1, 0, 4);
        set_req(1, 0, 64'h8000_0504, 64'd0, 8'h10);
        wait_resp("t5d");
        req_re = 0;
        @(negedge clk);

        // 6: SLVERR write response
        exp_addr = 32'h8000_0604; exp_size = 3'd2; exp_strb = 8'hf0; exp_wdata = 64'hCAFE_F00D_0000_0000;
        bresp_cfg = 2'b10;
        push_exp(64'd0, 0, ERR_EXP, 4);
        set_req(0, 1, 64'h8000_0604, 64'hCAFE_F00D_0000_0000, 8'hf0);
        wait_resp("t6");
        req_we = 0; bresp_cfg = 2'b00;
        @(negedge clk);

        // illegal mask: size 3, strobe passed through
        exp_addr = 32'h8000_0700; exp_size = 3'd3; exp_strb = 8'h07; exp_wdata = 64'h0000_0000_00AB_CDEF;
        push_exp(64'd0, 0, ERR_EXP, 4);
        set_req(0, 1, 64'h8000_0700, 64'h0000_0000_00AB_CDEF, 8'h07);
        wait_resp("t7");
        req_we = 0;
        @(negedge clk);

        // clean write after errors
        exp_addr = 32'h8000_0708; exp_size = 3'd3; exp_strb = 8'hff; exp_wdata = 64'h1357_9BDF_2468_ACE0;
        push_exp(64'd0, 0, 0, 4);
        set_req(0, 1, 64'h8000_0708, 64'h1357_9BDF_2468_ACE0, 8'hff);
        wait_resp("t8");
        req_we = 0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
